// File: rtl/mips_exe_stage.sv
// MIPS execute stage: ALU control decode, combinational ALU and the EXE/MEM pipeline register.
// The register clears asynchronously; the zeroed controls turn a discarded instruction into a no-op.
module mips_exe_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic [4:0]  shamt,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic [31:0] imm32,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic        alu_src,
   input  logic        reg_dst,
   input  logic        reg_write_e,
   input  logic        mem_to_reg_e,
   input  logic        mem_write_e,
   input  logic        mem_read_e,
   input  logic        load_full_word_e,
   input  logic        load_signed_e,
   output logic [3:0]  alu_op,
   output logic [31:0] alu_result,
   output logic        alu_zero,
   output logic [31:0] alu_result_m,
   output logic [31:0] rt_data_m,
   output logic [4:0]  write_reg_m,
   output logic        reg_write_m,
   output logic        mem_to_reg_m,
   output logic        mem_write_m,
   output logic        mem_read_m,
   output logic        load_full_word_m,
   output logic        load_signed_m
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SLL  = 4'b0011;
   localparam logic [3:0] OP_SRL  = 4'b0100;
   localparam logic [3:0] OP_SLTU = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_NOR  = 4'b1100;

   logic [3:0]         w_alu_op;
   logic signed [31:0] w_op_a;
   logic signed [31:0] w_op_b;
   logic [31:0]        w_result;
   logic [4:0]         w_write_reg;

   logic [31:0] r_alu_result;
   logic [31:0] r_rt_data;
   logic [4:0]  r_write_reg;
   logic        r_reg_write;
   logic        r_mem_to_reg;
   logic        r_mem_write;
   logic        r_mem_read;
   logic        r_load_full_word;
   logic        r_load_signed;

   // Unrecognised funct/opcode values fall back to ADD so address-style ops stay benign.
   always_comb begin
      w_alu_op = OP_ADD;
      if (opcode == 6'h00) begin
         case (funct)
            6'h20, 6'h21: w_alu_op = OP_ADD;
            6'h22, 6'h23: w_alu_op = OP_SUB;
            6'h24:        w_alu_op = OP_AND;
            6'h25:        w_alu_op = OP_OR;
            6'h27:        w_alu_op = OP_NOR;
            6'h2A:        w_alu_op = OP_SLT;
            6'h2B:        w_alu_op = OP_SLTU;
            6'h00:        w_alu_op = OP_SLL;
            6'h02:        w_alu_op = OP_SRL;
            default:      w_alu_op = OP_ADD;
         endcase
      end else begin
         case (opcode)
            6'h04, 6'h05: w_alu_op = OP_SUB;
            6'h0C:        w_alu_op = OP_AND;
            6'h0D:        w_alu_op = OP_OR;
            6'h0A:        w_alu_op = OP_SLT;
            6'h0B:        w_alu_op = OP_SLTU;
            default:      w_alu_op = OP_ADD;
         endcase
      end
   end

   assign w_op_a = rs_data;
   assign w_op_b = alu_src ? imm32 : rt_data;

   // Shifts take rt_data directly, bypassing the operand-B mux.
   always_comb begin
      w_result = 32'd0;
      case (w_alu_op)
         OP_AND:  w_result = w_op_a & w_op_b;
         OP_OR:   w_result = w_op_a | w_op_b;
         OP_NOR:  w_result = ~(w_op_a | w_op_b);
         OP_ADD:  w_result = w_op_a + w_op_b;
         OP_SUB:  w_result = w_op_a - w_op_b;
         OP_SLT:  w_result = {31'd0, (w_op_a < w_op_b)};
         OP_SLTU: w_result = {31'd0, ($unsigned(w_op_a) < $unsigned(w_op_b))};
         OP_SLL:  w_result = rt_data << shamt;
         OP_SRL:  w_result = rt_data >> shamt;
         default: w_result = 32'd0;
      endcase
   end

   assign w_write_reg = reg_dst ? rd : rt;

   assign alu_op     = w_alu_op;
   assign alu_result = w_result;
   assign alu_zero   = (w_result == 32'd0);

   // EXE/MEM boundary
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_alu_result     <= 32'd0;
         r_rt_data        <= 32'd0;
         r_write_reg      <= 5'd0;
         r_reg_write      <= 1'b0;
         r_mem_to_reg     <= 1'b0;
         r_mem_write      <= 1'b0;
         r_mem_read       <= 1'b0;
         r_load_full_word <= 1'b0;
         r_load_signed    <= 1'b0;
      end else if (enable) begin
         r_alu_result     <= w_result;
         r_rt_data        <= rt_data;
         r_write_reg      <= w_write_reg;
         r_reg_write      <= reg_write_e;
         r_mem_to_reg     <= mem_to_reg_e;
         r_mem_write      <= mem_write_e;
         r_mem_read       <= mem_read_e;
         r_load_full_word <= load_full_word_e;
         r_load_signed    <= load_signed_e;
      end
   end

   assign alu_result_m     = r_alu_result;
   assign rt_data_m        = r_rt_data;
   assign write_reg_m      = r_write_reg;
   assign reg_write_m      = r_reg_write;
   assign mem_to_reg_m     = r_mem_to_reg;
   assign mem_write_m      = r_mem_write;
   assign mem_read_m       = r_mem_read;
   assign load_full_word_m = r_load_full_word;
   assign load_signed_m    = r_load_signed;

endmodule

// File: tb/tb_mips_exe_stage.sv
// Directed bench for mips_exe_stage: decode, ALU results, EXE/MEM capture, hold and asynchronous reset.
module tb_mips_exe_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [31:0] imm32;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic        alu_src;
   logic        reg_dst;
   logic        reg_write_e;
   logic        mem_to_reg_e;
   logic        mem_write_e;
   logic        mem_read_e;
   logic        load_full_word_e;
   logic        load_signed_e;
   logic [3:0]  alu_op;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic [31:0] alu_result_m;
   logic [31:0] rt_data_m;
   logic [4:0]  write_reg_m;
   logic        reg_write_m;
   logic        mem_to_reg_m;
   logic        mem_write_m;
   logic        mem_read_m;
   logic        load_full_word_m;
   logic        load_signed_m;

   int checks = 0;
   int errors = 0;

   mips_exe_stage dut (
      .clk(clk), .reset(reset), .enable(enable),
      .opcode(opcode), .funct(funct), .shamt(shamt),
      .rs_data(rs_data), .rt_data(rt_data), .imm32(imm32),
      .rt(rt), .rd(rd), .alu_src(alu_src), .reg_dst(reg_dst),
      .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e),
      .mem_read_e(mem_read_e), .load_full_word_e(load_full_word_e), .load_signed_e(load_signed_e),
      .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
      .alu_result_m(alu_result_m), .rt_data_m(rt_data_m), .write_reg_m(write_reg_m),
      .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m), .mem_write_m(mem_write_m),
      .mem_read_m(mem_read_m), .load_full_word_m(load_full_word_m), .load_signed_m(load_signed_m)
   );

   always #5 clk = ~clk;

   task automatic drive_idle();
      enable = 1'b1; opcode = 6'h00; funct = 6'h20; shamt = 5'd0;
      rs_data = 32'd0; rt_data = 32'd0; imm32 = 32'd0; rt = 5'd0; rd = 5'd0;
      alu_src = 1'b0; reg_dst = 1'b0;
      reg_write_e = 1'b0; mem_to_reg_e = 1'b0; mem_write_e = 1'b0;
      mem_read_e = 1'b0; load_full_word_e = 1'b0; load_signed_e = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [75:0] pack_m();
      return {alu_result_m, rt_data_m, write_reg_m, reg_write_m, mem_to_reg_m,
              mem_write_m, mem_read_m, load_full_word_m, load_signed_m};
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      drive_idle();
      #1;
      checks++;
      if (pack_m() !== 76'd0) begin
         errors++; $display("FAIL reset_state: got %h expected 0", pack_m());
      end
      step();
      #2 reset = 1'b0;
   endtask

   task automatic test_addi();
      drive_idle();
      opcode = 6'h08; imm32 = 32'd5; alu_src = 1'b1; rt = 5'd17; reg_write_e = 1'b1;
      #1;
      checks++;
      if (alu_op !== 4'b0010) begin errors++; $display("FAIL addi_op: got %b expected 0010", alu_op); end
      checks++;
      if (alu_result !== 32'd5) begin errors++; $display("FAIL addi_comb: got %h expected 5", alu_result); end
      step();
      checks++;
      if ({alu_result_m, write_reg_m, reg_write_m} !== {32'd5, 5'd17, 1'b1}) begin
         errors++; $display("FAIL addi_reg: got res=%h wr=%0d rw=%b expected 5/17/1", alu_result_m, write_reg_m, reg_write_m);
      end
      imm32 = 32'hFFFF_FFFD; rt = 5'd18;
      #1;
      checks++;
      if (alu_zero !== 1'b0) begin errors++; $display("FAIL addi_neg_zero: got %b expected 0", alu_zero); end
      step();
      checks++;
      if ({alu_result_m, write_reg_m} !== {32'hFFFF_FFFD, 5'd18}) begin
         errors++; $display("FAIL addi_neg_reg: got %h/%0d expected fffffffd/18", alu_result_m, write_reg_m);
      end
   endtask

   task automatic test_store();
      drive_idle();
      opcode = 6'h2B; imm32 = 32'd5; alu_src = 1'b1; mem_write_e = 1'b1;
      step();
      checks++;
      if ({alu_result_m, mem_write_m, rt_data_m, reg_write_m} !== {32'd5, 1'b1, 32'd0, 1'b0}) begin
         errors++; $display("FAIL sw: got res=%h mw=%b rtd=%h rw=%b expected 5/1/0/0", alu_result_m, mem_write_m, rt_data_m, reg_write_m);
      end
      rs_data = 32'h0000_1000; rt_data = 32'hDEAD_BEEF; imm32 = 32'hFFFF_FFFC;
      step();
      checks++;
      if ({alu_result_m, rt_data_m} !== {32'h0000_0FFC, 32'hDEAD_BEEF}) begin
         errors++; $display("FAIL sw_data: got %h/%h expected 00000ffc/deadbeef", alu_result_m, rt_data_m);
      end
   endtask

   task automatic test_rtype();
      logic [5:0]  f_tab [3] = '{6'h24, 6'h25, 6'h27};
      logic [3:0]  o_tab [3] = '{4'b0000, 4'b0001, 4'b1100};
      logic [31:0] r_tab [3] = '{32'h00F0_000F, 32'hFFF0_0FFF, 32'h000F_F000};
      drive_idle();
      reg_dst = 1'b1; rd = 5'd19; reg_write_e = 1'b1; rt = 5'd3;
      #1;
      checks++;
      if ({alu_result, alu_zero} !== {32'd0, 1'b1}) begin
         errors++; $display("FAIL add_zero: got %h/%b expected 0/1", alu_result, alu_zero);
      end
      step();
      checks++;
      if (write_reg_m !== 5'd19) begin errors++; $display("FAIL add_dst: got %0d expected 19", write_reg_m); end
      funct = 6'h22; rs_data = 32'd5; rt_data = 32'd2; rd = 5'd9;
      #1;
      checks++;
      if (alu_op !== 4'b0110) begin errors++; $display("FAIL sub_op: got %b expected 0110", alu_op); end
      step();
      checks++;
      if ({alu_result_m, write_reg_m} !== {32'd3, 5'd9}) begin
         errors++; $display("FAIL sub_reg: got %h/%0d expected 3/9", alu_result_m, write_reg_m);
      end
      rs_data = 32'hF0F0_00FF; rt_data = 32'h0FF0_0F0F;
      for (int i = 0; i < 3; i++) begin
         funct = f_tab[i];
         #1;
         checks++;
         if ({alu_op, alu_result} !== {o_tab[i], r_tab[i]}) begin
            errors++; $display("FAIL logic_%0d: got %b/%h expected %b/%h", i, alu_op, alu_result, o_tab[i], r_tab[i]);
         end
      end
      funct = 6'h23; rs_data = 32'd0; rt_data = 32'd1;
      #1;
      checks++;
      if (alu_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL subu_wrap: got %h expected ffffffff", alu_result); end
   endtask

   task automatic test_shift_compare();
      drive_idle();
      funct = 6'h00; rt_data = 32'd1; shamt = 5'd4; alu_src = 1'b1; imm32 = 32'h0000_0100;
      #1;
      checks++;
      if ({alu_op, alu_result} !== {4'b0011, 32'd16}) begin
         errors++; $display("FAIL sll: got %b/%h expected 0011/10", alu_op, alu_result);
      end
      funct = 6'h02; rt_data = 32'h8000_0000; shamt = 5'd31;
      #1;
      checks++;
      if ({alu_op, alu_result} !== {4'b0100, 32'd1}) begin
         errors++; $display("FAIL srl: got %b/%h expected 0100/1", alu_op, alu_result);
      end
      alu_src = 1'b0; funct = 6'h2A; rs_data = 32'hFFFF_FFFF; rt_data = 32'd1;
      #1;
      checks++;
      if ({alu_op, alu_result} !== {4'b0111, 32'd1}) begin
         errors++; $display("FAIL slt: got %b/%h expected 0111/1", alu_op, alu_result);
      end
      funct = 6'h2B;
      #1;
      checks++;
      if ({alu_op, alu_result, alu_zero} !== {4'b0101, 32'd0, 1'b1}) begin
         errors++; $display("FAIL sltu: got %b/%h/%b expected 0101/0/1", alu_op, alu_result, alu_zero);
      end
   endtask

   task automatic test_itype_decode();
      logic [5:0] op_tab [8] = '{6'h0C, 6'h0D, 6'h0A, 6'h0B, 6'h04, 6'h05, 6'h23, 6'h3F};
      logic [3:0] ex_tab [8] = '{4'b0000, 4'b0001, 4'b0111, 4'b0101, 4'b0110, 4'b0110, 4'b0010, 4'b0010};
      drive_idle();
      funct = 6'h24;
      for (int i = 0; i < 8; i++) begin
         opcode = op_tab[i];
         #1;
         checks++;
         if (alu_op !== ex_tab[i]) begin
            errors++; $display("FAIL idec_%0h: got %b expected %b", op_tab[i], alu_op, ex_tab[i]);
         end
      end
      opcode = 6'h00; funct = 6'h3F;
      #1;
      checks++;
      if (alu_op !== 4'b0010) begin errors++; $display("FAIL rdec_default: got %b expected 0010", alu_op); end
   endtask

   task automatic test_hold();
      drive_idle();
      opcode = 6'h23; rs_data = 32'h100; imm32 = 32'h20; alu_src = 1'b1; rt = 5'd7;
      reg_write_e = 1'b1; mem_to_reg_e = 1'b1; mem_read_e = 1'b1; load_full_word_e = 1'b1; load_signed_e = 1'b1;
      rt_data = 32'h1234_5678;
      step();
      enable = 1'b0; rs_data = 32'h999; rt = 5'd2; rt_data = 32'd0;
      reg_write_e = 1'b0; mem_to_reg_e = 1'b0; mem_read_e = 1'b0; load_full_word_e = 1'b0; load_signed_e = 1'b0;
      step();
      step();
      checks++;
      if (pack_m() !== {32'h120, 32'h1234_5678, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1}) begin
         errors++; $display("FAIL hold: got %h expected %h", pack_m(),
                            {32'h120, 32'h1234_5678, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1});
      end
   endtask

   task automatic test_reset_mid();
      drive_idle();
      opcode = 6'h20; rs_data = 32'h40; imm32 = 32'h4; alu_src = 1'b1; rt = 5'd12; rt_data = 32'hAAAA_5555;
      reg_write_e = 1'b1; mem_to_reg_e = 1'b1; mem_write_e = 1'b1; mem_read_e = 1'b1;
      load_full_word_e = 1'b1; load_signed_e = 1'b1;
      step();
      checks++;
      if (pack_m() !== {32'h44, 32'hAAAA_5555, 5'd12, 6'b111111}) begin
         errors++; $display("FAIL preload: got %h", pack_m());
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (pack_m() !== 76'd0) begin errors++; $display("FAIL async_reset: got %h expected 0", pack_m()); end
      step();
      checks++;
      if (pack_m() !== 76'd0) begin errors++; $display("FAIL reset_over_enable: got %h expected 0", pack_m()); end
      #2 reset = 1'b0;
      step();
      checks++;
      if ({alu_result_m, write_reg_m, reg_write_m} !== {32'h44, 5'd12, 1'b1}) begin
         errors++; $display("FAIL resume: got %h/%0d/%b expected 44/12/1", alu_result_m, write_reg_m, reg_write_m);
      end
   endtask

   task automatic test_back_to_back();
      drive_idle();
      reg_dst = 1'b1; reg_write_e = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         rs_data = 32'(i * 100); rt_data = 32'(i); rd = 5'(i + 20);
         step();
         checks++;
         if ({alu_result_m, write_reg_m} !== {32'(i * 101), 5'(i + 20)}) begin
            errors++; $display("FAIL b2b_%0d: got %h/%0d expected %h/%0d", i, alu_result_m, write_reg_m, 32'(i * 101), i + 20);
         end
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_store();
      test_rtype();
      test_shift_compare();
      test_itype_decode();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
